// File: rtl/uart_burst_pkg.sv
// Shared types and constants for the UART burst sequencer.
// Contents: FSM state enum, terminator phase enum, ASCII CR/LF codes.
// The CR and LF states exist only when UART_BURST_CRLF_EN is defined.
package uart_burst_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_ACK,
        WAIT_DONE,
        GAP
`ifdef UART_BURST_CRLF_EN
        ,
        CR,
        LF
`endif
    } state_t;

    // Which character is currently in the UART handshake: a sequence
    // character, or one of the burst terminator bytes.
    typedef enum logic [1:0] {
        TERM_NONE,
        TERM_CR,
        TERM_LF
    } term_t;

endpackage

// File: rtl/burst_char_gen.sv
// Wrapping character register for the UART burst sequencer.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset, loads CHAR_FIRST
//   advance  - step to the next character (CHAR_LAST wraps to CHAR_FIRST)
//   data     - current sequence character
module burst_char_gen #(
    parameter logic [7:0] CHAR_FIRST = 8'h30,
    parameter logic [7:0] CHAR_LAST  = 8'h7A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [7:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= CHAR_FIRST;
        end else if (advance) begin
            data <= (data == CHAR_LAST) ? CHAR_FIRST : data + 8'd1;
        end
    end

endmodule

// File: rtl/uart_burst_seq.sv
// UART burst sequencer: on start, hands BURST_LEN consecutive characters to
// a UART transmitter one at a time using a uart_start / tx_busy handshake,
// with GAP_CYCLES idle cycles between characters. The character sequence
// carries on across bursts.
// Optional build macro UART_BURST_CRLF_EN: terminate each completed burst
// with CR then LF (not counted in sent_count, not part of the sequence).
// Ports:
//   clk, rst    - clock (rising edge), asynchronous active-high reset
//   start       - burst request, only honoured in IDLE
//   abort       - finish the character in flight, then stop (no done)
//   tx_busy     - UART transmitter busy flag
//   uart_start  - one-cycle transmit trigger
//   data        - character presented to the UART
//   busy        - FSM is not in IDLE
//   done        - one-cycle pulse when a burst completes normally
//   sent_count  - characters acknowledged in the current burst
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// FIRE      | uart_start pulse for the current character
// WAIT_ACK  | waiting for tx_busy to rise
// WAIT_DONE | waiting for tx_busy to fall; character complete on exit
// GAP       | inter-character idle time, abort leaves immediately
// CR / LF   | uart_start pulse for a terminator byte (CRLF build only)
module uart_burst_seq
    import uart_burst_pkg::*;
#(
    parameter int         BURST_LEN  = 16,
    parameter logic [7:0] CHAR_FIRST = 8'h30,
    parameter logic [7:0] CHAR_LAST  = 8'h7A,
    parameter int         GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       tx_busy,
    output logic       uart_start,
    output logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic [7:0] sent_count
);

    localparam logic [7:0]  LAST_COUNT = 8'(BURST_LEN);
    // The gap counter counts down to zero, so it is loaded with one less.
    localparam logic [15:0] GAP_LOAD   = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t      state_q, state_d;
    logic [15:0] gap_q, gap_d;
    logic        abort_q, abort_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  count_inc;
    logic        done_d;
    logic        advance;
    logic [7:0]  seq_char;
`ifdef UART_BURST_CRLF_EN
    term_t       term_q, term_d;
`endif

    burst_char_gen #(
        .CHAR_FIRST (CHAR_FIRST),
        .CHAR_LAST  (CHAR_LAST)
    ) u_char_gen (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .data    (seq_char)
    );

    assign count_inc  = count_q + 8'd1;
    assign busy       = (state_q != IDLE);
    assign sent_count = count_q;

`ifdef UART_BURST_CRLF_EN
    always_comb begin
        case (term_q)
            TERM_CR: data = ASCII_CR;
            TERM_LF: data = ASCII_LF;
            default: data = seq_char;
        endcase
    end
`else
    assign data = seq_char;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
            abort_q <= 1'b0;
            count_q <= '0;
            done    <= 1'b0;
`ifdef UART_BURST_CRLF_EN
            term_q  <= TERM_NONE;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            abort_q <= abort_d;
            count_q <= count_d;
            done    <= done_d;
`ifdef UART_BURST_CRLF_EN
            term_q  <= term_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        abort_d    = abort_q;
        count_d    = count_q;
        done_d     = 1'b0;
        advance    = 1'b0;
        uart_start = 1'b0;
`ifdef UART_BURST_CRLF_EN
        term_d     = term_q;
`endif
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    state_d = FIRE;
                    count_d = '0;
                end
            end
            FIRE: begin
                uart_start = 1'b1;
                state_d    = WAIT_ACK;
                if (abort) abort_d = 1'b1;
            end
            WAIT_ACK: begin
                if (abort) abort_d = 1'b1;
                if (tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (abort) abort_d = 1'b1;
                if (!tx_busy) begin
`ifdef UART_BURST_CRLF_EN
                    if (term_q == TERM_CR) begin
                        state_d = LF;
                        term_d  = TERM_LF;
                    end else if (term_q == TERM_LF) begin
                        state_d = IDLE;
                        term_d  = TERM_NONE;
                        done_d  = 1'b1;
                        abort_d = 1'b0;
                    end else
`endif
                    begin
                        count_d = count_inc;
                        advance = 1'b1;
                        // Final character wins over a simultaneous abort.
                        if (count_inc == LAST_COUNT) begin
                            abort_d = 1'b0;
`ifdef UART_BURST_CRLF_EN
                            state_d = CR;
                            term_d  = TERM_CR;
`else
                            state_d = IDLE;
                            done_d  = 1'b1;
`endif
                        end else if (abort || abort_q) begin
                            state_d = IDLE;
                            abort_d = 1'b0;
                        end else if (GAP_CYCLES == 0) begin
                            state_d = FIRE;
                        end else begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_q == 16'd0) begin
                    state_d = FIRE;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
`ifdef UART_BURST_CRLF_EN
            CR, LF: begin
                uart_start = 1'b1;
                state_d    = WAIT_ACK;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule
